alu_issue_sequencer: RTL and testbench
======================================

# alu_issue_sequencer

Multi-cycle issue and writeback controller sitting between the execute-stage issue logic and the ALU/flag register. It accepts one operation at a time over a valid/ready handshake, holds the ALU inputs stable for the op's execution latency, and commits flags exactly once. It then serializes the one or two results (MUL/DIV produce two) onto the single register-file write port, stalling upstream while it does so.

## Interface
- DATA_W, 16, datapath width
- REG_AW, 3, register-file address width
- MULDIV_LAT, 2, EXEC cycles for MUL/DIV (≥1); all other ops take 1
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  issue request
- in_ready  out  1  sequencer can accept
- in_alu_en  in  1  1 = arithmetic/logic op, 0 = LBL/LBH/MOV class
- in_opcode  in  5  opcode (`ADD, `MUL, … macros from parameters.v)
- in_op1, in_op2  in  DATA_W  operands
- in_bitpos  in  4  bit position for SETB/CLRB/CPLB/SETF/CLRF/CPLF
- in_imm  in  8  immediate for LBL/LBH
- in_rd  in  REG_AW  destination register
- alu_en, alu_opcode, alu_operand_1, alu_operand_2, alu_bit_position, alu_immediate  out  1/5/DATA_W/DATA_W/4/8  ALU inputs
- alu_result_0, alu_result_1, alu_next_flags  in  DATA_W each  ALU outputs
- current_flags  in  16  flag register output
- flags_out  out  16  flag register input
- wb_en  out  1  register write strobe
- wb_addr  out  REG_AW  register write address
- wb_data  out  DATA_W  register write data
- busy  out  1  not IDLE

## Operation
- FSM states: IDLE, EXEC, WB0, WB1.
- IDLE: in_ready=1. in_valid&in_ready latches all in_* fields → EXEC with cnt = (alu_en & op∈{MUL,DIV}) ? MULDIV_LAT-1 : 0.
- EXEC: ALU ports driven from latched fields, stable throughout. cnt decrements each cycle. When cnt==0: capture alu_result_0/1 into r0/r1, set div0 = (op==DIV & op2==0), → WB0.
- Flag commit: flags_out = alu_next_flags only in the final EXEC cycle of an alu_en=1 op; otherwise flags_out = current_flags (flag register holds).
- WB0: wb_en=1, wb_addr=rd, wb_data=r0. Exception: CMP, SETF, CLRF, CPLF assert wb_en=0. Next state is WB1 if alu_en & op∈{MUL,DIV} & !div0, else IDLE.
- WB1: wb_en=1, wb_addr=(rd+1) mod 2^REG_AW (wraps 7→0), wb_data=r1 → IDLE.
- Divide by zero: only FFFF written to rd. V flag comes from the ALU.
- alu_en=0 ops (LBL/LBH/MOV): single write, flags unchanged.
- Unknown opcode with alu_en=1: flags committed as ALU returns them, r0 written.
- r1 is sampled only for MUL/DIV. Otherwise it is ignored.

## Timing
- Reset values: state=IDLE, in_ready=1, busy=0, wb_en=0, wb_addr=0, wb_data=0, all latched fields/r0/r1=0, flags_out=current_flags.
- Reset mid-operation: immediately return to IDLE; the pending op is dropped, with no write and no commit.
- Handshake: accept edge = cycle 0. Single-cycle op: EXEC in cycle 1 (flags commit at end of cycle 1), WB0 in cycle 2, in_ready=1 again in cycle 3.
- MUL/DIV: EXEC cycles 1..MULDIV_LAT, WB0 at MULDIV_LAT+1, WB1 at MULDIV_LAT+2, ready at MULDIV_LAT+3.
- in_ready=0 in every non-IDLE state. No accept is possible in a WB cycle. in_valid held high while busy is not consumed.
- Outputs wb_* are registered (state-decoded from registered r0/r1/rd).

## Structure
- Shared parameters file gains: FSM state encodings and the op-class localparams/functions is_muldiv(opcode) and writes_reg(opcode). Opcode macros are reused unchanged.
- One natural combinational sub-module: alu_op_class (opcode, alu_en → is_muldiv, writes_reg, is_flag_only), also reusable by the hazard unit.
- The ALU and Flag_Register are instantiated beside this block, not inside it.

## Test plan
- ADD 0x7FFF+0x0001 to rd=2 → WB0 cycle 2: wb_addr=2, wb_data=0x8000. Flags latched with C=0, V=1, N=1, Z=0, P=0.
- MUL 0x1234×0x0100, rd=7, MULDIV_LAT=2 → cycle 3: addr 7 data 0x3400. Cycle 4: addr 0 (wrap) data 0x0012. in_ready at cycle 5.
- DIV 0x0010/0x0000, rd=1 → single write addr 1 data 0xFFFF, no WB1, V=1.
- CMP 0x0005,0x0005 → wb_en never asserted, Eq=1, Z=1, CMP=0, C=0. MOV (alu_en=0) op2=0xBEEF → write 0xBEEF, flags unchanged.
- Back-to-back: in_valid held for two ops → second accepted only in the first IDLE cycle after WB. No write is lost or duplicated.
- reset asserted during WB0 of a MUL → no WB1, state IDLE, wb_en=0 immediately, in_ready=1 after release.

Source files
------------

// File: rtl/alu_issue_sequencer_pkg.sv
// Shared opcode encodings, flag bit positions, sequencer state encoding and
// opcode-class helpers for the execute-stage issue/writeback logic.
package alu_issue_sequencer_pkg;

    // Arithmetic/logic opcodes (alu_en = 1)
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd4;
    localparam logic [4:0] OP_OR   = 5'd5;
    localparam logic [4:0] OP_XOR  = 5'd6;
    localparam logic [4:0] OP_NOT  = 5'd7;
    localparam logic [4:0] OP_CMP  = 5'd8;
    localparam logic [4:0] OP_SETB = 5'd9;
    localparam logic [4:0] OP_CLRB = 5'd10;
    localparam logic [4:0] OP_CPLB = 5'd11;
    localparam logic [4:0] OP_SETF = 5'd12;
    localparam logic [4:0] OP_CLRF = 5'd13;
    localparam logic [4:0] OP_CPLF = 5'd14;

    // Load/move opcodes (alu_en = 0) share the low code points
    localparam logic [4:0] OP_LBL  = 5'd0;
    localparam logic [4:0] OP_LBH  = 5'd1;
    localparam logic [4:0] OP_MOV  = 5'd2;

    localparam int FLAG_C   = 0;
    localparam int FLAG_V   = 1;
    localparam int FLAG_N   = 2;
    localparam int FLAG_Z   = 3;
    localparam int FLAG_P   = 4;
    localparam int FLAG_EQ  = 5;
    localparam int FLAG_CMP = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB0  = 2'd2,
        ST_WB1  = 2'd3
    } seq_state_t;

    function automatic logic is_muldiv(input logic [4:0] opcode);
        return (opcode == OP_MUL) || (opcode == OP_DIV);
    endfunction

    function automatic logic writes_reg(input logic [4:0] opcode);
        return !((opcode == OP_CMP) || (opcode == OP_SETF) ||
                 (opcode == OP_CLRF) || (opcode == OP_CPLF));
    endfunction

endpackage

// File: rtl/alu_issue_sequencer_if.sv
// Issue handshake and register-file write port of the issue sequencer.
interface alu_issue_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
);
    logic              in_valid;
    logic              in_ready;
    logic              in_alu_en;
    logic [4:0]        in_opcode;
    logic [DATA_W-1:0] in_op1;
    logic [DATA_W-1:0] in_op2;
    logic [3:0]        in_bitpos;
    logic [7:0]        in_imm;
    logic [REG_AW-1:0] in_rd;
    logic              wb_en;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    modport master (
        output in_valid, in_alu_en, in_opcode, in_op1, in_op2, in_bitpos, in_imm, in_rd,
        input  in_ready, wb_en, wb_addr, wb_data
    );

    modport slave (
        input  in_valid, in_alu_en, in_opcode, in_op1, in_op2, in_bitpos, in_imm, in_rd,
        output in_ready, wb_en, wb_addr, wb_data
    );
endinterface

// File: rtl/alu_issue_sequencer_op_class.sv
// Opcode classification shared by the issue sequencer and the hazard unit.
module alu_op_class (
    input  logic [4:0] opcode,
    input  logic       alu_en,
    output logic       is_muldiv,
    output logic       writes_reg,
    output logic       is_flag_only
);
    // Load/move ops reuse low opcode values, so every class is gated by alu_en.
    always_comb begin
        is_muldiv    = alu_en && alu_issue_sequencer_pkg::is_muldiv(opcode);
        is_flag_only = alu_en && !alu_issue_sequencer_pkg::writes_reg(opcode);
        writes_reg   = !is_flag_only;
    end
endmodule

// File: rtl/alu_issue_sequencer.sv
// Multi-cycle issue/writeback sequencer: holds ALU inputs for the op latency,
// commits flags once, then serialises one or two results onto the write port.
module alu_issue_sequencer
    import alu_issue_sequencer_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_AW     = 3,
    parameter int MULDIV_LAT = 2
) (
    input  logic                clk,
    input  logic                reset,
    alu_issue_sequencer_if.slave bus,
    output logic                alu_en,
    output logic [4:0]          alu_opcode,
    output logic [DATA_W-1:0]   alu_operand_1,
    output logic [DATA_W-1:0]   alu_operand_2,
    output logic [3:0]          alu_bit_position,
    output logic [7:0]          alu_immediate,
    input  logic [DATA_W-1:0]   alu_result_0,
    input  logic [DATA_W-1:0]   alu_result_1,
    input  logic [DATA_W-1:0]   alu_next_flags,
    input  logic [15:0]         current_flags,
    output logic [15:0]         flags_out,
    output logic                busy
);
    localparam int CNT_W = $clog2(MULDIV_LAT + 1);
    localparam logic [CNT_W-1:0] MD_CNT = CNT_W'(MULDIV_LAT - 1);

    seq_state_t        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              en_reg;
    logic [4:0]        opcode_reg;
    logic [DATA_W-1:0] op1_reg;
    logic [DATA_W-1:0] op2_reg;
    logic [3:0]        bitpos_reg;
    logic [7:0]        imm_reg;
    logic [REG_AW-1:0] rd_reg;
    logic [DATA_W-1:0] r0_reg;
    logic [DATA_W-1:0] r1_reg;
    logic              div0_reg;

    logic lat_muldiv;
    logic lat_writes;
    logic lat_flag_only;

    alu_op_class u_lat_class (
        .opcode       (opcode_reg),
        .alu_en       (en_reg),
        .is_muldiv    (lat_muldiv),
        .writes_reg   (lat_writes),
        .is_flag_only (lat_flag_only)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            en_reg     <= 1'b0;
            opcode_reg <= '0;
            op1_reg    <= '0;
            op2_reg    <= '0;
            bitpos_reg <= '0;
            imm_reg    <= '0;
            rd_reg     <= '0;
            r0_reg     <= '0;
            r1_reg     <= '0;
            div0_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        en_reg     <= bus.in_alu_en;
                        opcode_reg <= bus.in_opcode;
                        op1_reg    <= bus.in_op1;
                        op2_reg    <= bus.in_op2;
                        bitpos_reg <= bus.in_bitpos;
                        imm_reg    <= bus.in_imm;
                        rd_reg     <= bus.in_rd;
                        cnt_reg    <= (bus.in_alu_en && is_muldiv(bus.in_opcode)) ? MD_CNT : '0;
                        state_reg  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt_reg == '0) begin
                        // Flag-only ops leave the result register untouched.
                        if (!lat_flag_only) begin
                            r0_reg <= alu_result_0;
                        end
                        if (lat_muldiv) begin
                            r1_reg <= alu_result_1;
                        end
                        div0_reg  <= en_reg && (opcode_reg == OP_DIV) && (op2_reg == '0);
                        state_reg <= ST_WB0;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_WB0: begin
                    state_reg <= (lat_muldiv && !div0_reg) ? ST_WB1 : ST_IDLE;
                end
                ST_WB1: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_en           = en_reg;
    assign alu_opcode       = opcode_reg;
    assign alu_operand_1    = op1_reg;
    assign alu_operand_2    = op2_reg;
    assign alu_bit_position = bitpos_reg;
    assign alu_immediate    = imm_reg;

    // The ALU result is only committed in the last execute cycle of a real ALU op.
    assign flags_out = ((state_reg == ST_EXEC) && (cnt_reg == '0) && en_reg)
                       ? 16'(alu_next_flags) : current_flags;

    assign bus.in_ready = (state_reg == ST_IDLE);
    assign busy         = (state_reg != ST_IDLE);
    assign bus.wb_en    = ((state_reg == ST_WB0) && lat_writes) || (state_reg == ST_WB1);
    assign bus.wb_addr  = (state_reg == ST_WB1) ? rd_reg + 1'b1 : rd_reg;
    assign bus.wb_data  = (state_reg == ST_WB1) ? r1_reg : r0_reg;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Scoreboard bench for alu_issue_sequencer with a behavioural ALU and flag register.
module tb_alu_issue_sequencer;
    import alu_issue_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_issue_sequencer_if #(.DATA_W(16), .REG_AW(3)) bus();

    logic        alu_en;
    logic [4:0]  alu_opcode;
    logic [15:0] alu_operand_1, alu_operand_2;
    logic [3:0]  alu_bit_position;
    logic [7:0]  alu_immediate;
    logic [15:0] alu_result_0, alu_result_1, alu_next_flags;
    logic [15:0] current_flags, flags_out;
    logic        busy;

    alu_issue_sequencer #(.DATA_W(16), .REG_AW(3), .MULDIV_LAT(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .alu_en           (alu_en),
        .alu_opcode       (alu_opcode),
        .alu_operand_1    (alu_operand_1),
        .alu_operand_2    (alu_operand_2),
        .alu_bit_position (alu_bit_position),
        .alu_immediate    (alu_immediate),
        .alu_result_0     (alu_result_0),
        .alu_result_1     (alu_result_1),
        .alu_next_flags   (alu_next_flags),
        .current_flags    (current_flags),
        .flags_out        (flags_out),
        .busy             (busy)
    );

    // Flag register beside the sequencer (not reset by the sequencer reset)
    logic [15:0] flag_reg = 16'h0000;
    assign current_flags = flag_reg;
    always @(posedge clk) flag_reg <= flags_out;

    function automatic logic [15:0] nzp(input logic [15:0] f, input logic [15:0] v);
        f[FLAG_N] = v[15];
        f[FLAG_Z] = (v == 16'h0000);
        f[FLAG_P] = !v[15] && (v != 16'h0000);
        return f;
    endfunction

    // Behavioural ALU; non-ALU ops return scrambled flags so a wrong commit shows.
    logic [16:0] sum17;
    logic [31:0] prod32;
    always_comb begin
        sum17          = {1'b0, alu_operand_1} + {1'b0, alu_operand_2};
        prod32         = {16'h0000, alu_operand_1} * {16'h0000, alu_operand_2};
        alu_result_0   = 16'h0000;
        alu_result_1   = 16'h0000;
        alu_next_flags = flag_reg;
        if (!alu_en) begin
            alu_result_0   = alu_operand_2;
            alu_next_flags = ~flag_reg;
        end else begin
            case (alu_opcode)
                OP_ADD: begin
                    alu_result_0           = sum17[15:0];
                    alu_next_flags         = nzp(flag_reg, sum17[15:0]);
                    alu_next_flags[FLAG_C] = sum17[16];
                    alu_next_flags[FLAG_V] = (alu_operand_1[15] == alu_operand_2[15]) &&
                                             (sum17[15] != alu_operand_1[15]);
                end
                OP_MUL: begin
                    alu_result_0           = prod32[15:0];
                    alu_result_1           = prod32[31:16];
                    alu_next_flags         = nzp(flag_reg, prod32[15:0]);
                    alu_next_flags[FLAG_C] = |prod32[31:16];
                    alu_next_flags[FLAG_V] = |prod32[31:16];
                end
                OP_DIV: begin
                    if (alu_operand_2 == 16'h0000) begin
                        alu_result_0 = 16'hFFFF;
                        alu_result_1 = alu_operand_1;
                    end else begin
                        alu_result_0 = alu_operand_1 / alu_operand_2;
                        alu_result_1 = alu_operand_1 % alu_operand_2;
                    end
                    alu_next_flags         = nzp(flag_reg, alu_result_0);
                    alu_next_flags[FLAG_V] = (alu_operand_2 == 16'h0000);
                end
                OP_CMP: begin
                    alu_result_0             = alu_operand_1 - alu_operand_2;
                    alu_next_flags[FLAG_EQ]  = (alu_operand_1 == alu_operand_2);
                    alu_next_flags[FLAG_Z]   = (alu_operand_1 == alu_operand_2);
                    alu_next_flags[FLAG_CMP] = (alu_operand_1 > alu_operand_2);
                    alu_next_flags[FLAG_C]   = (alu_operand_1 < alu_operand_2);
                end
                default: begin
                    alu_result_0   = alu_operand_1 ^ alu_operand_2;
                    alu_next_flags = flag_reg | 16'h0100;
                end
            endcase
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
        int          cyc;
        string       tag;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("check %s = 0x%0h", name, act);
        end
    endtask

    task automatic expect_wr(input logic [2:0] a, input logic [15:0] d, input int c, input string tag);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: every register write is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (bus.wb_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%h cyc=%0d expected no write",
                         bus.wb_addr, bus.wb_data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.wb_addr !== mon_e.addr || bus.wb_data !== mon_e.data || cyc != mon_e.cyc) begin
                    failures++;
                    $display("FAIL write_%s: got addr=%0d data=0x%h cyc=%0d expected addr=%0d data=0x%h cyc=%0d",
                             mon_e.tag, bus.wb_addr, bus.wb_data, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
                end else begin
                    $display("write %s addr=%0d data=0x%h cyc=%0d", mon_e.tag, bus.wb_addr, bus.wb_data, cyc);
                end
            end
        end
    end

    // Presents an op and returns just after its accept edge; t0 is the cycle
    // index seen on the negedge before that edge.
    task automatic issue(input logic en, input logic [4:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] rd, output int t0);
        int n;
        @(negedge clk);
        bus.in_alu_en = en;
        bus.in_opcode = op;
        bus.in_op1    = a;
        bus.in_op2    = b;
        bus.in_rd     = rd;
        bus.in_bitpos = a[3:0];
        bus.in_imm    = b[7:0];
        bus.in_valid  = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready=%b expected 1", bus.in_ready);
        end
        t0 = cyc;
        @(posedge clk);
    endtask

    task automatic wait_ready(input int t0, input int k, input string name);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({"ready_cycle_", name}, 32'(cyc - t0), 32'(k));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    int t, ta, tb;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_alu_en = 1'b0;
        bus.in_opcode = 5'd0;
        bus.in_op1    = 16'h0000;
        bus.in_op2    = 16'h0000;
        bus.in_bitpos = 4'd0;
        bus.in_imm    = 8'd0;
        bus.in_rd     = 3'd0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wb_en", 32'(bus.wb_en), 32'd0);
        chk("rst_wb_addr", 32'(bus.wb_addr), 32'd0);
        chk("rst_wb_data", 32'(bus.wb_data), 32'd0);
        chk("rst_operand_1", 32'(alu_operand_1), 32'd0);
        chk("rst_imm_bitpos", {20'd0, alu_immediate, alu_bit_position}, 32'd0);
        chk("rst_flags_hold", 32'(flags_out), 32'(flag_reg));
        reset = 1'b0;

        issue(1'b1, OP_ADD, 16'h7FFF, 16'h0001, 3'd2, t);
        expect_wr(3'd2, 16'h8000, t + 2, "add");
        wait_ready(t, 3, "add");
        chk("flags_add", 32'(flag_reg), 32'h0006);

        issue(1'b1, OP_CMP, 16'h0005, 16'h0005, 3'd6, t);
        wait_ready(t, 3, "cmp");
        chk("flags_cmp", 32'(flag_reg), 32'h002E);

        issue(1'b0, OP_MOV, 16'h1111, 16'hBEEF, 3'd4, t);
        expect_wr(3'd4, 16'hBEEF, t + 2, "mov");
        wait_ready(t, 3, "mov");
        chk("flags_mov", 32'(flag_reg), 32'h002E);

        issue(1'b1, OP_DIV, 16'h0010, 16'h0000, 3'd1, t);
        expect_wr(3'd1, 16'hFFFF, t + 3, "div0");
        wait_ready(t, 4, "div0");
        chk("flags_div0", 32'(flag_reg), 32'h0026);

        issue(1'b1, OP_MUL, 16'h1234, 16'h0100, 3'd7, t);
        expect_wr(3'd7, 16'h3400, t + 3, "mul_lo");
        expect_wr(3'd0, 16'h0012, t + 4, "mul_hi");
        wait_ready(t, 5, "mul");
        chk("flags_mul", 32'(flag_reg), 32'h0033);

        issue(1'b1, 5'h1F, 16'h00F0, 16'h0F00, 3'd0, t);
        expect_wr(3'd0, 16'h0FF0, t + 2, "unknown");
        wait_ready(t, 3, "unknown");
        chk("flags_unknown", 32'(flag_reg), 32'h0133);

        // in_valid stays high across both ops
        issue(1'b1, OP_ADD, 16'h0001, 16'h0001, 3'd3, ta);
        expect_wr(3'd3, 16'h0002, ta + 2, "b2b_add");
        issue(1'b0, OP_MOV, 16'h0000, 16'h1357, 3'd5, tb);
        chk("b2b_accept_gap", 32'(tb - ta), 32'd3);
        expect_wr(3'd5, 16'h1357, tb + 2, "b2b_mov");
        wait_ready(tb, 3, "b2b");
        chk("flags_b2b", 32'(flag_reg), 32'h0130);

        issue(1'b1, OP_DIV, 16'h0011, 16'h0004, 3'd3, t);
        expect_wr(3'd3, 16'h0004, t + 3, "div_q");
        expect_wr(3'd4, 16'h0001, t + 4, "div_r");
        wait_ready(t, 5, "div");
        chk("flags_div", 32'(flag_reg), 32'h0130);

        // Reset lands in WB0 of a MUL: the WB1 write must never appear.
        issue(1'b1, OP_MUL, 16'h0002, 16'h0003, 3'd6, t);
        expect_wr(3'd6, 16'h0006, t + 3, "mul_rst_lo");
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_wb_en", 32'(bus.wb_en), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("postrst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
